// File: rtl/fsm_seq_pkg.sv
// ============================================================================
// fsm_seq_pkg : shared types, default sizes and helpers for the sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fsm_seq_pkg;

  localparam int DEF_PAT_W = 16;
  localparam int DEF_LEN_W = 5;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsm_seq_hit_ctr.sv
// ============================================================================
// fsm_seq_hit_ctr : saturating hit counter with first-hit index capture
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fsm_seq_hit_ctr
  import fsm_seq_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             sample_en_i,
  input  logic             z_i,
  input  logic [LEN_W-1:0] idx_i,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [LEN_W-1:0] first_hit_idx_o,
  output logic             hit_valid_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] first_q, first_d;
  logic             valid_q, valid_d;

  always_comb begin
    count_d = count_q;
    first_d = first_q;
    valid_d = valid_q;
    if (clr_i) begin
      count_d = '0;
      first_d = '0;
      valid_d = 1'b0;
    end else if (sample_en_i && z_i) begin
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
      if (!valid_q) begin
        first_d = idx_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      first_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      first_q <= first_d;
      valid_q <= valid_d;
    end
  end

  assign hit_count_o     = count_q;
  assign first_hit_idx_o = first_q;
  assign hit_valid_o     = valid_q;

endmodule

`default_nettype wire

// File: rtl/fsm_seq_ctrl.sv
// ============================================================================
// fsm_seq_ctrl : shifts a programmed pattern into a Moore detector and counts
//                its hits. Option macro: FSM_SEQ_STOP_ON_HIT_EN.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module fsm_seq_ctrl
  import fsm_seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] length_i,
  output logic             det_x_o,
  output logic             det_clr_o,
  input  logic             det_z_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [LEN_W-1:0] first_hit_idx_o,
  output logic             hit_valid_o
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_q, bit_d;

  logic             start_acc;
  logic             sample_en;
  logic             stop_hit;
  logic [LEN_W-1:0] sample_idx;
  logic [LEN_W-1:0] bit_sel;
  logic [PAT_W-1:0] pat_shift;
  logic [LEN_W-1:0] len_clamped;

  assign len_clamped = LEN_W'(clamp_len(32'(length_i), 32'(PAT_W)));
  assign bit_sel     = len_q - bit_q - LEN_ONE;
  assign pat_shift   = pattern_q >> bit_sel;

  // z lags x by one cycle, so the sample taken while sending bit n belongs to bit n-1
  assign sample_en  = ((state_q == ST_SHIFT) && (bit_q != '0)) ||
                      ((state_q == ST_DRAIN) && (len_q != '0));
  assign sample_idx = (state_q == ST_SHIFT) ? (bit_q - LEN_ONE) : (len_q - LEN_ONE);

`ifdef FSM_SEQ_STOP_ON_HIT_EN
  assign stop_hit = sample_en & det_z_i;
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    bit_d     = bit_q;
    start_acc = 1'b0;
    det_x_o   = 1'b0;
    det_clr_o = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          pattern_d = pattern_i;
          len_d     = len_clamped;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy_o    = 1'b1;
        det_clr_o = 1'b1;
        bit_d     = '0;
        state_d   = (len_q == '0) ? ST_DRAIN : ST_SHIFT;
      end
      ST_SHIFT: begin
        busy_o  = 1'b1;
        det_x_o = pat_shift[0] & ~stop_hit;
        bit_d   = bit_q + LEN_ONE;
        if (stop_hit) begin
          state_d = ST_DONE;
        end else if (bit_q == (len_q - LEN_ONE)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_o  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      bit_q     <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
    end
  end

  fsm_seq_hit_ctr #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_hit_ctr (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clr_i           (start_acc),
    .sample_en_i     (sample_en),
    .z_i             (det_z_i),
    .idx_i           (sample_idx),
    .hit_count_o     (hit_count_o),
    .first_hit_idx_o (first_hit_idx_o),
    .hit_valid_o     (hit_valid_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_fsm_seq_ctrl.sv
// ============================================================================
// tb_fsm_seq_ctrl : self-checking bench with an overlapping "101" detector
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_fsm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0]  length = '0;
  logic        det_x, det_clr, det_z, busy, done, hit_valid;
  logic [7:0]  hit_count;
  logic [4:0]  first_hit_idx;

  always #5 clk = ~clk;

  fsm_seq_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .pattern_i       (pattern),
    .length_i        (length),
    .det_x_o         (det_x),
    .det_clr_o       (det_clr),
    .det_z_i         (det_z),
    .busy_o          (busy),
    .done_o          (done),
    .hit_count_o     (hit_count),
    .first_hit_idx_o (first_hit_idx),
    .hit_valid_o     (hit_valid)
  );

  // Overlapping "101" Moore detector: z is high when the last three bits seen were 1,0,1
  logic [2:0] d_hist;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       d_hist <= 3'b000;
    else if (det_clr) d_hist <= 3'b000;
    else              d_hist <= {d_hist[1:0], det_x};
  end
  assign det_z = (d_hist == 3'b101);

`ifdef FSM_SEQ_STOP_ON_HIT_EN
  localparam bit STOP_MODE = 1'b1;
  localparam int EXP_DONE_10101 = 6;
  localparam int EXP_CNT_10101  = 1;
`else
  localparam bit STOP_MODE = 1'b0;
  localparam int EXP_DONE_10101 = 8;
  localparam int EXP_CNT_10101  = 2;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: run timeline derived from the bit list and a 101-window scan
  logic [15:0] m_pat;
  int m_L, m_c, m_E, m_xstop, m_cnt, m_first;
  bit m_run = 1'b0, m_valid;
  int r_cnt = 0, r_first = 0;
  bit r_valid = 1'b0;

  function automatic int model_bit(input int i);
    return int'(m_pat[m_L-1-i]);
  endfunction

  task automatic model_accept();
    m_pat   = pattern;
    m_L     = (int'(length) > 16) ? 16 : int'(length);
    m_cnt   = 0;
    m_first = 0;
    m_valid = 1'b0;
    for (int i = 2; i < m_L; i++) begin
      if (model_bit(i-2) == 1 && model_bit(i-1) == 0 && model_bit(i) == 1) begin
        if (!m_valid) begin
          m_valid = 1'b1;
          m_first = i;
        end
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_E     = m_L + 3;
    m_xstop = 1000;
    if (STOP_MODE && m_valid) begin
      m_cnt   = 1;
      m_E     = m_first + 4;
      m_xstop = m_first + 3;
    end
    m_c   = 0;
    m_run = 1'b1;
  endtask

  initial begin : compare
    int ex, eclr, ebusy, edone;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_run   = 1'b0;
        r_cnt   = 0;
        r_first = 0;
        r_valid = 1'b0;
        check("rst_det_x", det_x, 0);
        check("rst_det_clr", det_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_first_hit_idx", first_hit_idx, 0);
        check("rst_hit_valid", hit_valid, 0);
      end else begin
        if (!m_run && start) model_accept();
        ex = 0; eclr = 0; ebusy = 0; edone = 0;
        if (m_run) begin
          eclr  = (m_c == 1) ? 1 : 0;
          ebusy = (m_c >= 1 && m_c < m_E) ? 1 : 0;
          edone = (m_c == m_E) ? 1 : 0;
          if (m_c >= 2 && m_c <= m_L + 1 && m_c < m_xstop) ex = model_bit(m_c - 2);
        end
        check("det_x", det_x, ex);
        check("det_clr", det_clr, eclr);
        check("busy", busy, ebusy);
        check("done", done, edone);
        if (m_run && m_c == 1) begin
          check("hit_count_zeroed", hit_count, 0);
          check("first_hit_idx_zeroed", first_hit_idx, 0);
          check("hit_valid_zeroed", hit_valid, 0);
        end else if (m_run && m_c == m_E) begin
          check("hit_count", hit_count, m_cnt);
          check("first_hit_idx", first_hit_idx, m_first);
          check("hit_valid", hit_valid, m_valid);
        end else if (!m_run || m_c == 0) begin
          check("hit_count_held", hit_count, r_cnt);
          check("first_hit_idx_held", first_hit_idx, r_first);
          check("hit_valid_held", hit_valid, r_valid);
        end
        if (m_run) begin
          if (m_c == m_E) begin
            m_run   = 1'b0;
            r_cnt   = m_cnt;
            r_first = m_first;
            r_valid = m_valid;
          end else begin
            m_c++;
          end
        end
      end
    end
  end

  // mode 0: single start pulse; 1: extra start during SHIFT; 2: reset in cycle 4; 3: start held for two runs
  task automatic run_one(input logic [15:0] p, input logic [4:0] l, input int mode, output int dc);
    int dc2;
    @(posedge clk); #2;
    start   = 1'b1;
    pattern = p;
    length  = l;
    dc = -1;
    for (int k = 0; k < 40 && dc < 0; k++) begin
      @(negedge clk);
      if (done) dc = k;
      @(posedge clk); #2;
      if (k == 0 && mode != 3) begin
        start   = 1'b0;
        pattern = 16'($urandom);
        length  = 5'($urandom);
      end
      if (mode == 1 && k == 3) start = 1'b1;
      if (mode == 1 && k == 4) start = 1'b0;
      if (mode == 2 && k == 3) begin
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        break;
      end
    end
    if (dc < 0 && mode != 2) check("done_timeout", 0, 1);
    if (mode == 3 && dc >= 0) begin
      @(posedge clk); #2;
      start = 1'b0;
      dc2 = -1;
      for (int k = 0; k < 40 && dc2 < 0; k++) begin
        @(negedge clk);
        if (done) dc2 = k;
      end
      if (dc2 < 0) check("retrigger_done_timeout", 0, 1);
      @(posedge clk); #2;
    end
  endtask

  initial begin : main
    int dc;
    int l, m;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_one(16'b10101, 5'd5, 0, dc);
    check("lit_done_cycle_10101", dc, EXP_DONE_10101);
    check("lit_hit_count_10101", hit_count, EXP_CNT_10101);
    check("lit_first_idx_10101", first_hit_idx, 2);
    check("lit_hit_valid_10101", hit_valid, 1);

    run_one(16'h0000, 5'd4, 0, dc);
    check("lit_done_cycle_zeros", dc, 7);
    check("lit_hit_count_zeros", hit_count, 0);
    check("lit_hit_valid_zeros", hit_valid, 0);
    check("lit_first_idx_zeros", first_hit_idx, 0);

    run_one(16'hA5A5, 5'd0, 0, dc);
    check("lit_done_cycle_len0", dc, 3);
    check("lit_hit_count_len0", hit_count, 0);

    run_one(16'hFFFF, 5'd20, 0, dc);
    check("lit_done_cycle_clamp", dc, 19);

    run_one(16'h0155, 5'd10, 1, dc);
    run_one(16'h0155, 5'd10, 2, dc);
    check("lit_no_done_on_reset", dc, -1);

    run_one(16'b10101, 5'd5, 0, dc);
    check("lit_done_cycle_after_reset", dc, EXP_DONE_10101);
    check("lit_hit_count_after_reset", hit_count, EXP_CNT_10101);

    run_one(16'h2D6B, 5'd12, 3, dc);

    for (int n = 0; n < 60; n++) begin
      l = $urandom_range(0, 20);
      m = $urandom_range(0, 3);
      if (m == 2) m = 0;
      if (m == 1 && l < 5) m = 0;
      run_one(16'($urandom), 5'(l), m, dc);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
Sequencer that drives a programmed serial bit pattern into a single-input Moore detector FSM (x in, z out) and collects its detections. It clears the detector, shifts up to PAT_W bits MSB-first, one per clock, and compensates for the Moore one-cycle output lag. It reports hit count and first-hit index through a start/busy/done handshake. It sits between a host/config register block and one detector instance.

Parameters:
PAT_W, 16, maximum pattern length in bits
LEN_W, 5, width of length input; must be at least $clog2(PAT_W+1)
CNT_W, 8, width of the hit counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a run; sampled only in IDLE
pattern  in  PAT_W  bit pattern; captured on the start-accept cycle
length  in  LEN_W  number of bits to send; captured on start; values above PAT_W are clamped to PAT_W
det_x  out  1  serial bit to detector x
det_clr  out  1  synchronous clear pulse to detector
det_z  in  1  detector Moore output z
busy  out  1  high from the cycle after start-accept until done
done  out  1  one-cycle pulse at end of run
hit_count  out  CNT_W  number of z samples equal to 1 in the last run; saturates at all-ones
first_hit_idx  out  LEN_W  bit index (0 = first bit sent) of the first hit
hit_valid  out  1  at least one hit seen in the last run

Behaviour:
- Reset (reset=0, async):
  - state IDLE
  - det_x=0, det_clr=0, busy=0, done=0
  - hit_count=0, first_hit_idx=0, hit_valid=0
  - internal registers cleared
- Reset mid-run aborts immediately with no done pulse.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- Timing, with cycle 0 = IDLE cycle in which start=1:
  - Cycle 0: pattern and clamped length are latched. hit_count, hit_valid and first_hit_idx are zeroed.
  - Cycle 1 (CLEAR): det_clr=1, det_x=0.
  - Cycles 2..L+1 (SHIFT): det_x = pattern_q[L-1-i] for bit i = cycle-2.
  - Cycle L+2 (DRAIN): det_x=0.
  - Cycle L+3 (DONE): done=1.
  - Cycle L+4: back in IDLE.
- busy=1 in CLEAR, SHIFT and DRAIN; busy=0 in DONE and IDLE.
- z sampling:
  - det_z is sampled in cycles 3..L+2, giving exactly L samples.
  - The sample in cycle c belongs to bit c-3.
  - The z value in cycle 2 reflects the post-clear state and is ignored.
- On each sample with det_z=1:
  - hit_count increments, saturating at 2^CNT_W-1.
  - If hit_valid=0: first_hit_idx is set to the bit index and hit_valid is set to 1.
- Results are held stable from DONE until the next start-accept.
- L=0: the run goes CLEAR -> DRAIN -> DONE. No SHIFT cycles, no samples, hit_count=0. done is asserted in cycle 3.
- start while not in IDLE is ignored. start held high re-triggers on the IDLE cycle after DONE.
- Changes to pattern or length during a run have no effect.

Optional Feature:
Macro FSM_SEQ_STOP_ON_HIT_EN.
- Defined: the first z sample equal to 1 ends the run.
  - The next state is DONE, skipping the remaining SHIFT bits and DRAIN.
  - det_x=0 from that point.
  - hit_count=1, hit_valid=1, first_hit_idx = index of that bit.
- Undefined: every run sends all L bits and counts all hits, as specified above.

Decomposition:
- Package fsm_seq_pkg holds:
  - state enum (IDLE, CLEAR, SHIFT, DRAIN, DONE)
  - PAT_W, LEN_W, CNT_W default constants
  - a clamp-length function
- Sub-module fsm_seq_hit_ctr holds:
  - the saturating hit counter
  - first-hit index capture and hit_valid
  - inputs: clr, sample_en, z, idx
- The top level keeps the FSM, pattern/length registers, bit index counter and det_x/det_clr drive.

Test Plan:
All scenarios run against a behavioural overlapping "101" Moore detector.
- pattern=16'b10101, length=5 -> det_x sequence 1,0,1,0,1 in cycles 2..6; done in cycle 8; hit_count=2, first_hit_idx=2, hit_valid=1.
- pattern=16'b0000, length=4 -> done in cycle 7; hit_count=0, hit_valid=0, first_hit_idx=0.
- length=0 -> det_clr pulse in cycle 1, done in cycle 3, no det_x activity, hit_count=0.
- length=20 with PAT_W=16 -> clamped to 16 bits; done in cycle 19.
- start pulses during SHIFT -> ignored. reset=0 asserted in cycle 4 of a run -> all outputs 0 immediately, no done pulse. A new start after release runs normally.
- With FSM_SEQ_STOP_ON_HIT_EN defined, pattern=16'b10101, length=5 -> done in cycle 6; hit_count=1, first_hit_idx=2; det_x=0 from cycle 5.
